// File: rtl/emmc_blk_ctrl_p.sv
// Shared types for the eMMC block controller: FSM state encoding and watchdog scope.
package emmc_blk_ctrl_p;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WSTART,
    WXFER,
    RSTART,
    RXFER,
    RDRAIN
  } state_t;

  // States in which the card is expected to make progress; the watchdog only runs here.
  function automatic logic wd_active(input state_t s);
    return s inside {WSTART, WXFER, RSTART, RXFER};
  endfunction

endpackage

// File: rtl/emmc_blk_ram.sv
// Single-port block buffer: synchronous write, registered read (data one cycle after address).
module emmc_blk_ram #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/emmc_blk_ctrl.sv
// Block-level buffer between a byte-stream user port and the eMMC card state machine.
// Writes fill one block then stream it out; reads collect one block then drain it with valid/ready.
module emmc_blk_ctrl
  import emmc_blk_ctrl_p::*;
#(
  parameter int BLK_BYTES   = 512,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  input  logic       rd_req_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  input  logic       rd_ready_i,
  output logic       sm_we_o,
  output logic       sm_start_o,
  output logic [7:0] sm_dat_o,
  input  logic [7:0] sm_dat_i,
  input  logic       sm_dvalid_i,
  input  logic       sm_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = $clog2(BLK_BYTES);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST   = CW'(BLK_BYTES - 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYC - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WW-1:0] wd;
  logic          start, start_nx;
  logic          we_dir, we_dir_nx;
  logic          err, err_nx;
  logic          drain_rdy;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  logic xfer, cnt_full, dv_take, rd_take, timeout;

  assign xfer     = state inside {WXFER, RXFER};
  assign cnt_full = cnt[AW];
  assign dv_take  = sm_dvalid_i && xfer && !cnt_full;
  assign rd_take  = rd_valid_o && rd_ready_i;
  assign timeout  = wd_active(state) && !dv_take && (wd == WD_LIM);

  assign wr_ready_o = state inside {IDLE, WFILL};
  assign busy_o     = (state != IDLE);
  assign rd_valid_o = (state == RDRAIN) && drain_rdy;
  assign rd_data_o  = ram_rdata;
  assign sm_dat_o   = ram_rdata;
  assign sm_start_o = start;
  assign sm_we_o    = we_dir;
  assign err_o      = err;

  // The RAM address looks one byte ahead on a consumed beat so the registered
  // read output always presents buf[cnt] in WXFER and RDRAIN.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    start_nx  = 1'b0;
    we_dir_nx = we_dir;
    err_nx    = err;
    ram_we    = 1'b0;
    ram_addr  = cnt[AW-1:0];
    ram_wdata = wr_data_i;
    case (state)
      IDLE: begin
        ram_addr = '0;
        if (wr_valid_i) begin
          ram_we   = 1'b1;
          cnt_nx   = CW'(1);
          state_nx = WFILL;
        end else if (rd_req_i) begin
          state_nx = RSTART;
        end
      end
      WFILL: begin
        if (wr_valid_i) begin
          ram_we = 1'b1;
          cnt_nx = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nx = WSTART;
          end
        end
      end
      WSTART, RSTART: begin
        ram_addr = '0;
        if (timeout) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (sm_ready_i) begin
          start_nx  = 1'b1;
          we_dir_nx = (state == WSTART);
          err_nx    = 1'b0;
          cnt_nx    = '0;
          state_nx  = (state == WSTART) ? WXFER : RXFER;
        end
      end
      WXFER: begin
        ram_addr = cnt[AW-1:0] + AW'(dv_take);
        if (timeout) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (cnt_full && sm_ready_i) begin
          state_nx = IDLE;
        end else if (dv_take) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RXFER: begin
        ram_we    = dv_take;
        ram_wdata = sm_dat_i;
        if (timeout) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (cnt_full && sm_ready_i) begin
          cnt_nx   = '0;
          state_nx = RDRAIN;
        end else if (dv_take) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RDRAIN: begin
        ram_addr = cnt[AW-1:0] + AW'(rd_take);
        if (rd_take) begin
          if (cnt == LAST) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == IDLE) begin
      cnt_nx    = '0;
      we_dir_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      wd        <= '0;
      start     <= 1'b0;
      we_dir    <= 1'b0;
      err       <= 1'b0;
      drain_rdy <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      start     <= start_nx;
      we_dir    <= we_dir_nx;
      err       <= err_nx;
      // First RDRAIN cycle only primes the registered read.
      drain_rdy <= (state == RDRAIN) && (state_nx == RDRAIN);
      if ((state_nx != state) || !wd_active(state) || dv_take) begin
        wd <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

  emmc_blk_ram #(
    .DEPTH(BLK_BYTES)
  ) u_ram (
    .clk  (clk_i),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_emmc_blk_ctrl.sv
// Randomized bench for emmc_blk_ctrl: byte queues model the block content end to end.
module tb_emmc_blk_ctrl;

  localparam int BLK = 512;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst, wr_valid, rd_req, rd_ready, sm_dvalid, sm_ready;
  logic [7:0] wr_data, sm_din;
  logic       wr_ready, rd_valid, sm_we, sm_start, busy, err;
  logic [7:0] rd_data, sm_dout;

  always #5 clk = ~clk;

  emmc_blk_ctrl #(
    .BLK_BYTES  (BLK),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .rd_req_i   (rd_req),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .rd_ready_i (rd_ready),
    .sm_we_o    (sm_we),
    .sm_start_o (sm_start),
    .sm_dat_o   (sm_dout),
    .sm_dat_i   (sm_din),
    .sm_dvalid_i(sm_dvalid),
    .sm_ready_i (sm_ready),
    .busy_o     (busy),
    .err_o      (err)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_start = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic       wr_chk = 1'b0;
  logic       exp_we = 1'b0;
  logic       smp_start = 1'b0;
  logic       smp_err = 1'b0;
  logic       smp_wr_ready = 1'b0;
  logic [7:0] cap_w0, cap_w255, cap_w256, cap_r0, cap_r511;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare outputs at the falling edge, return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    smp_start    = sm_start;
    smp_err      = err;
    smp_wr_ready = wr_ready;
    if (!rst) begin
      if (sm_start) begin
        n_start++;
        check("sm_we_o_at_start", 32'(sm_we), 32'(exp_we));
      end
      if (wr_chk && sm_dvalid && wr_idx < exp_wr.size()) begin
        if (wr_idx == 0)   cap_w0   = sm_dout;
        if (wr_idx == 255) cap_w255 = sm_dout;
        if (wr_idx == 256) cap_w256 = sm_dout;
        check("sm_dat_o", 32'(sm_dout), 32'(exp_wr[wr_idx]));
        wr_idx++;
      end
      if (rd_valid) begin
        if (rd_idx < exp_rd.size()) begin
          if (rd_idx == 0)   cap_r0   = rd_data;
          if (rd_idx == 511) cap_r511 = rd_data;
          check("rd_data_o", 32'(rd_data), 32'(exp_rd[rd_idx]));
        end else begin
          check("rd_valid_o_extra", 32'(rd_valid), 32'(0));
        end
        if (rd_ready) rd_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     32'(busy),     32'(0));
    check({tag, "_err"},      32'(err),      32'(0));
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'(1));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_start"},    32'(sm_start), 32'(0));
    check({tag, "_we"},       32'(sm_we),    32'(0));
  endtask

  task automatic push_block(input int rnd);
    logic [7:0] b;
    logic       all_rdy;
    all_rdy = 1'b1;
    exp_wr.delete();
    wr_idx = 0;
    for (int i = 0; i < BLK; i++) begin
      b = (rnd != 0) ? 8'($urandom) : 8'(i);
      wr_valid = 1'b1;
      wr_data  = b;
      exp_wr.push_back(b);
      step();
      all_rdy &= smp_wr_ready;
    end
    wr_valid = 1'b0;
    check("wr_ready_during_fill", 32'(all_rdy), 32'(1));
  endtask

  task automatic fill_rd(input int rnd);
    exp_rd.delete();
    rd_idx = 0;
    for (int i = 0; i < BLK; i++) begin
      exp_rd.push_back((rnd != 0) ? 8'($urandom) : 8'(i ^ 'hA5));
    end
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!smp_start && k < 200) begin
      step();
      k++;
    end
    check(nm, 32'(smp_start), 32'(1));
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    check(nm, 32'(busy), 32'(0));
  endtask

  // Card side of a write: back-to-back strobes, then two surplus strobes that must be ignored.
  task automatic card_write_xfer();
    wr_chk = 1'b1;
    for (int i = 0; i < BLK + 2; i++) begin
      sm_dvalid = 1'b1;
      step();
    end
    sm_dvalid = 1'b0;
    wr_chk    = 1'b0;
    check("wr_bytes_seen", 32'(wr_idx), 32'(BLK));
  endtask

  task automatic card_read_xfer(input int nbytes);
    int gap;
    for (int i = 0; i < nbytes; i++) begin
      gap = $urandom_range(0, 3);
      sm_dvalid = 1'b0;
      repeat (gap) step();
      sm_dvalid = 1'b1;
      sm_din    = exp_rd[i];
      step();
    end
    sm_dvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (busy && k < 4000) begin
      rd_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    rd_ready = 1'b0;
    check({tag, "_drain_idle"},  32'(busy),   32'(0));
    check({tag, "_drain_count"}, 32'(rd_idx), 32'(BLK));
  endtask

  initial begin
    int s0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; rd_ready = 1'b0;
    sm_dvalid = 1'b0; sm_ready = 1'b1; sm_din = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Counting-pattern write block
    exp_we = 1'b1;
    push_block(0);
    check("wr_ready_after_fill", 32'(wr_ready), 32'(0));
    wait_start("wr_start");
    card_write_xfer();
    wait_idle("wr_done");
    check("wr_start_count", 32'(n_start), 32'(1));
    check("lit_w0",   32'(cap_w0),   32'(8'h00));
    check("lit_w255", 32'(cap_w255), 32'(8'hFF));
    check("lit_w256", 32'(cap_w256), 32'(8'h00));

    // Read block of i^0xA5 with random card gaps and random user backpressure
    exp_we = 1'b0;
    fill_rd(0);
    rd_req = 1'b1;
    wait_start("rd_start");
    rd_req = 1'b0;
    card_read_xfer(BLK);
    drain("rd");
    check("rd_start_count", 32'(n_start), 32'(2));
    check("lit_r0",   32'(cap_r0),   32'(8'hA5));
    check("lit_r511", 32'(cap_r511), 32'(8'h5A));

    // Simultaneous write and read request: write first, read follows
    exp_we = 1'b1;
    rd_req = 1'b1;
    push_block(1);
    wait_start("both_wr_start");
    card_write_xfer();
    exp_we = 1'b0;
    fill_rd(1);
    wait_start("both_rd_start");
    rd_req = 1'b0;
    card_read_xfer(BLK);
    drain("both");
    check("both_start_count", 32'(n_start), 32'(4));

    // Card not ready in WSTART, then a stalled transfer that must time out
    sm_ready = 1'b0;
    exp_we   = 1'b1;
    push_block(1);
    s0 = n_start;
    for (int i = 0; i < 50; i++) begin
      step();
      check("start_held_off", 32'(smp_start), 32'(0));
    end
    check("busy_in_wstart", 32'(busy), 32'(1));
    sm_ready = 1'b1;
    wait_start("late_start");
    for (int i = 0; i < 5; i++) begin
      step();
      check("single_start", 32'(smp_start), 32'(0));
    end
    check("late_start_count", 32'(n_start - s0), 32'(1));
    wr_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sm_dvalid = 1'b1;
      step();
    end
    sm_dvalid = 1'b0;
    check("partial_wr_count", 32'(wr_idx), 32'(10));
    for (int k = 1; k < TO; k++) begin
      step();
      check("err_before_timeout", 32'(err), 32'(0));
    end
    step();
    wr_chk = 1'b0;
    check("err_at_timeout",     32'(err),   32'(1));
    check("busy_after_timeout", 32'(busy),  32'(0));
    check("we_after_timeout",   32'(sm_we), 32'(0));
    repeat (3) step();
    check("err_sticky", 32'(err), 32'(1));

    // Next request clears err at its start pulse; reset lands mid-RXFER
    exp_we = 1'b0;
    fill_rd(1);
    rd_req = 1'b1;
    step();
    check("err_until_start", 32'(err), 32'(1));
    wait_start("clr_start");
    check("err_clr_at_start", 32'(smp_err), 32'(0));
    rd_req = 1'b0;
    card_read_xfer(200);
    check("busy_mid_rxfer", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    check_idle_outputs("mid_rst");
    rst = 1'b0;

    fill_rd(1);
    rd_req = 1'b1;
    wait_start("fresh_start");
    rd_req = 1'b0;
    card_read_xfer(BLK);
    drain("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
